// File: rtl/mux_nx1_pipe_pkg.sv
// Shared definitions for the N:1 operand select pipeline: word width defaults,
// the out-of-range fill word and the skid-slice state encoding.
package mux_nx1_pipe_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] BAD_VAL_DEF = '0;

   typedef enum logic [1:0] {
      SB_EMPTY = 2'd0,
      SB_ONE   = 2'd1,
      SB_FULL  = 2'd2
   } sb_state_t;

   // Select width for n inputs, never below one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      for (int i = 1; i <= 30; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_nx1_pipe_skid.sv
// Two-entry valid/ready register slice (main + skid) with synchronous flush.
// in_ready is a register, so it never depends combinationally on out_ready.
//
// state    | meaning
// SB_EMPTY | nothing held, out_valid=0, in_ready=1
// SB_ONE   | main holds the head word, skid empty
// SB_FULL  | main and skid both hold words, in_ready=0
module mux_nx1_pipe_skid
   import mux_nx1_pipe_pkg::*;
#(
   parameter int WIDTH = WORD_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   sb_state_t        r_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             r_out_valid;
   logic             r_in_ready;
   logic             w_accept;
   logic             w_pop;

   assign w_accept  = in_valid & r_in_ready;
   assign w_pop     = r_out_valid & out_ready;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_main;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= SB_EMPTY;
         r_main      <= '0;
         r_skid      <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else if (flush) begin
         // Data registers keep stale contents; they are invisible while out_valid=0.
         r_state     <= SB_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            SB_EMPTY: begin
               if (w_accept) begin
                  r_main      <= in_data;
                  r_out_valid <= 1'b1;
                  r_state     <= SB_ONE;
               end
            end
            SB_ONE: begin
               if (w_pop && w_accept) begin
                  r_main <= in_data;
               end else if (w_pop) begin
                  r_out_valid <= 1'b0;
                  r_state     <= SB_EMPTY;
               end else if (w_accept) begin
                  r_skid     <= in_data;
                  r_in_ready <= 1'b0;
                  r_state    <= SB_FULL;
               end
            end
            SB_FULL: begin
               if (w_pop) begin
                  r_main     <= r_skid;
                  r_in_ready <= 1'b1;
                  r_state    <= SB_ONE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= SB_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/mux_nx1_pipe.sv
// W-bit N:1 operand select feeding a two-entry skid slice, with a sticky flag
// for accepted out-of-range selects.
module mux_nx1_pipe
   import mux_nx1_pipe_pkg::*;
#(
   parameter int               WIDTH   = WORD_W,
   parameter int               NUM_IN  = 4,
   parameter logic [WIDTH-1:0] BAD_VAL = WIDTH'(BAD_VAL_DEF),
   localparam int              SEL_W   = clog2_min1(NUM_IN)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] din,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        dout,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err,
   input  logic                    err_clr
);

   logic [WIDTH-1:0] w_word;
   logic             w_sel_bad;
   logic             w_accept;
   logic             r_sel_err;

   always_comb begin
      w_word = BAD_VAL;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) w_word = din[k*WIDTH +: WIDTH];
      end
   end

   // A power-of-two input count covers every select code.
   generate
      if ((1 << SEL_W) == NUM_IN) begin : g_full_range
         assign w_sel_bad = 1'b0;
      end else begin : g_part_range
         assign w_sel_bad = (sel >= SEL_W'(NUM_IN));
      end
   endgenerate

   // A word offered during flush is discarded, so it cannot raise the flag.
   assign w_accept = in_valid & in_ready & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel_err <= 1'b0;
      end else if (w_accept && w_sel_bad) begin
         r_sel_err <= 1'b1;
      end else if (err_clr) begin
         r_sel_err <= 1'b0;
      end
   end

   assign sel_err = r_sel_err;

   mux_nx1_pipe_skid #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_data   (w_word),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (dout),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: three configurations (16b/4in, 16b/3in, 32b/5in)
// share control stimulus and are checked every cycle against a queue model.
module tb_mux_nx1_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic in_valid  = 1'b0;
   logic out_ready = 1'b0;
   logic flush     = 1'b0;
   logic err_clr   = 1'b0;

   logic [31:0] dw [3][5];
   logic [2:0]  sel_v [3];

   logic [63:0]  din_a;
   logic [47:0]  din_b;
   logic [159:0] din_c;
   logic [15:0]  dout_a;
   logic [15:0]  dout_b;
   logic [31:0]  dout_c;
   logic [2:0]   ov;
   logic [2:0]   ir;
   logic [2:0]   se;

   int          nin  [3] = '{4, 3, 5};
   logic [31:0] mask [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};

   int checks   = 0;
   int failures = 0;

   always_comb begin
      din_a = '0;
      din_b = '0;
      din_c = '0;
      for (int k = 0; k < 4; k++) din_a[k*16 +: 16] = dw[0][k][15:0];
      for (int k = 0; k < 3; k++) din_b[k*16 +: 16] = dw[1][k][15:0];
      for (int k = 0; k < 5; k++) din_c[k*32 +: 32] = dw[2][k];
   end

   mux_nx1_pipe #(.WIDTH(16), .NUM_IN(4)) dut_a (
      .clk(clk), .rst(rst), .din(din_a), .sel(sel_v[0][1:0]), .in_valid(in_valid),
      .in_ready(ir[0]), .flush(flush), .dout(dout_a), .out_valid(ov[0]),
      .out_ready(out_ready), .sel_err(se[0]), .err_clr(err_clr));

   mux_nx1_pipe #(.WIDTH(16), .NUM_IN(3)) dut_b (
      .clk(clk), .rst(rst), .din(din_b), .sel(sel_v[1][1:0]), .in_valid(in_valid),
      .in_ready(ir[1]), .flush(flush), .dout(dout_b), .out_valid(ov[1]),
      .out_ready(out_ready), .sel_err(se[1]), .err_clr(err_clr));

   mux_nx1_pipe #(.WIDTH(32), .NUM_IN(5)) dut_c (
      .clk(clk), .rst(rst), .din(din_c), .sel(sel_v[2]), .in_valid(in_valid),
      .in_ready(ir[2]), .flush(flush), .dout(dout_c), .out_valid(ov[2]),
      .out_ready(out_ready), .sel_err(se[2]), .err_clr(err_clr));

   function automatic logic [31:0] act_dout(input int d);
      case (d)
         0:       return {16'h0000, dout_a};
         1:       return {16'h0000, dout_b};
         default: return dout_c;
      endcase
   endfunction

   function automatic logic [31:0] word_of(input int d);
      int s;
      s = int'(sel_v[d]);
      if (s < nin[d]) return dw[d][s] & mask[d];
      return 32'h0;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Model: each DUT is an order-preserving buffer of at most two words.
   logic [31:0] mq [3][$];
   logic        merr [3] = '{1'b0, 1'b0, 1'b0};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            merr[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            int sz;
            bit acc;
            sz  = mq[d].size();
            acc = in_valid && (sz < 2) && !flush;
            if (flush) begin
               mq[d].delete();
            end else begin
               if (sz > 0 && out_ready) mq[d].delete(0);
               if (acc) mq[d].push_back(word_of(d));
            end
            if (acc && int'(sel_v[d]) >= nin[d]) merr[d] = 1'b1;
            else if (err_clr) merr[d] = 1'b0;
         end
      end
   end

   logic        stab_need = 1'b0;
   logic [31:0] stab_val  = '0;
   always @(posedge clk) begin
      stab_need <= !rst && ov[2] && !out_ready;
      stab_val  <= dout_c;
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d_out_valid", d), {31'h0, ov[d]}, {31'h0, mq[d].size() > 0});
            check($sformatf("dut%0d_in_ready", d), {31'h0, ir[d]}, {31'h0, mq[d].size() < 2});
            check($sformatf("dut%0d_sel_err", d), {31'h0, se[d]}, {31'h0, merr[d]});
            if (mq[d].size() > 0 && ov[d])
               check($sformatf("dut%0d_dout", d), act_dout(d), mq[d][0]);
         end
         if (stab_need && ov[2]) check("dut2_dout_stable", dout_c, stab_val);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_sel(input logic [2:0] s);
      for (int d = 0; d < 3; d++) sel_v[d] = s;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; err_clr = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 3; d++)
         for (int k = 0; k < 5; k++) dw[d][k] = 32'h1000_0000 + 32'(k);
      for (int k = 0; k < 4; k++) dw[0][k] = 32'h1111 * 32'(k + 1);
      for (int k = 0; k < 3; k++) dw[1][k] = 32'h1111 * 32'(k + 1);
      set_sel(3'd0);

      // Reset state
      do_reset();
      check("rst_out_valid", {31'h0, ov[0]}, 32'h0);
      check("rst_in_ready", {31'h0, ir[0]}, 32'h1);
      check("rst_sel_err", {31'h0, se[1]}, 32'h0);
      check("rst_dout", {16'h0, dout_a}, 32'h0);

      // Streaming at full rate
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_sel(3'(i));
         step();
         check($sformatf("stream_dout%0d", i), {16'h0, dout_a}, 32'h1111 * 32'(i + 1));
         check($sformatf("stream_ready%0d", i), {31'h0, ir[0]}, 32'h1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drain", {31'h0, ov[0]}, 32'h0);

      // Backpressure
      do_reset();
      in_valid = 1'b1; out_ready = 1'b0;
      set_sel(3'd0); step();
      check("bp_first_ready", {31'h0, ir[0]}, 32'h1);
      set_sel(3'd1); step();
      check("bp_full_ready", {31'h0, ir[0]}, 32'h0);
      set_sel(3'd2); step();
      check("bp_hold_dout", {16'h0, dout_a}, 32'h1111);
      out_ready = 1'b1; step();
      check("bp_pop1_dout", {16'h0, dout_a}, 32'h2222);
      check("bp_pop1_ready", {31'h0, ir[0]}, 32'h1);
      step();
      check("bp_pop2_dout", {16'h0, dout_a}, 32'h3333);
      in_valid = 1'b0; step();
      check("bp_empty", {31'h0, ov[0]}, 32'h0);

      // Flush while full, with a word offered and the consumer ready
      do_reset();
      in_valid = 1'b1; out_ready = 1'b0;
      set_sel(3'd0); step();
      set_sel(3'd1); step();
      flush = 1'b1; out_ready = 1'b1; set_sel(3'd2); step();
      check("flush_out_valid", {31'h0, ov[0]}, 32'h0);
      check("flush_in_ready", {31'h0, ir[0]}, 32'h1);
      flush = 1'b0; in_valid = 1'b0; step(); step();
      check("flush_no_word", {31'h0, ov[0]}, 32'h0);

      // Out-of-range select on the 3-input instance
      do_reset();
      dw[1][0] = 32'hABCD;
      in_valid = 1'b1; out_ready = 1'b1; set_sel(3'd3); step();
      check("bad_dout", {16'h0, dout_b}, 32'h0000);
      check("bad_sel_err", {31'h0, se[1]}, 32'h1);
      check("pow2_no_err", {31'h0, se[0]}, 32'h0);
      in_valid = 1'b0; flush = 1'b1; step();
      check("flush_keeps_err", {31'h0, se[1]}, 32'h1);
      flush = 1'b0; in_valid = 1'b1; err_clr = 1'b1; step();
      check("set_beats_clr", {31'h0, se[1]}, 32'h1);
      in_valid = 1'b0; step();
      check("clr_alone", {31'h0, se[1]}, 32'h0);
      err_clr = 1'b0; in_valid = 1'b1; set_sel(3'd0); step();
      check("good_dout", {16'h0, dout_b}, 32'hABCD);

      // Asynchronous reset between edges with words in flight
      in_valid = 1'b1; out_ready = 1'b0; set_sel(3'd3); step(); step();
      check("pre_rst_err", {31'h0, se[1]}, 32'h1);
      @(posedge clk); #2 rst = 1'b1; #1;
      check("arst_out_valid", {29'h0, ov}, 32'h0);
      check("arst_in_ready", {29'h0, ir}, 32'h7);
      check("arst_sel_err", {29'h0, se}, 32'h0);
      in_valid = 1'b0;
      @(negedge clk); rst = 1'b0;

      // Random soak
      repeat (10000) begin
         in_valid  = ($urandom_range(0, 99) < 65);
         out_ready = ($urandom_range(0, 99) < 60);
         flush     = ($urandom_range(0, 99) < 3);
         err_clr   = ($urandom_range(0, 99) < 5);
         sel_v[0]  = 3'($urandom_range(0, 3));
         sel_v[1]  = 3'($urandom_range(0, 3));
         sel_v[2]  = 3'($urandom_range(0, 7));
         for (int d = 0; d < 3; d++)
            for (int k = 0; k < 5; k++) dw[d][k] = $urandom;
         @(negedge clk);
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      step(); step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised successor of the 16-bit 2:1 operand mux: W-bit, N-input select with a registered, flow-controlled output stage.
- Intended for execute-stage operand and forwarding selection, where downstream stalls must not drop or duplicate operands.
- Output stage is a 2-entry skid buffer (main + skid), so in_ready is a registered signal and never combinationally depends on out_ready.
- Flags out-of-range selects.

Parameters:
- WIDTH, 16, data bits per input.
- NUM_IN, 4, number of data inputs (2..16).
- SEL_W, clog2(NUM_IN) (min 1), select width; derived, not overridden.
- BAD_VAL, all-zeros, word emitted for an out-of-range select.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- sel  in  SEL_W  binary select, sampled with din.
- in_valid  in  1  din/sel valid.
- in_ready  out  1  block can accept this cycle.
- flush  in  1  synchronous pipeline flush (branch/exception).
- dout  out  WIDTH  selected word (head entry).
- out_valid  out  1  dout valid.
- out_ready  in  1  consumer accepts dout.
- sel_err  out  1  sticky: an out-of-range select was accepted.
- err_clr  in  1  clears sel_err.

Behaviour:
- Reset (async, immediate): main/skid valid=0, out_valid=0, in_ready=1, dout=0, sel_err=0, data registers=0.
- Handshake definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid need not be held; sel/din are sampled only on accept.
- Selection: word = din slice sel when sel < NUM_IN, else BAD_VAL. Purely combinational before the register.
- Latency: an accepted word appears on dout with out_valid=1 the next cycle when the output is empty or popping. Throughput is 1 word/cycle under continuous out_ready.
- States, as (main_v, skid_v):
  - EMPTY (0,0): accept -> ONE, word loads main.
  - ONE (1,0):
    - pop & accept -> ONE, main <= word.
    - pop only -> EMPTY.
    - accept only -> FULL, word loads skid.
    - neither -> hold.
  - FULL (1,1): in_ready=0, so no accept.
    - pop -> ONE, main <= skid.
    - else hold.
- in_ready = !skid_v (registered).
- Ordering: strict FIFO. No word is dropped or duplicated.
- dout is stable while out_valid=1 and out_ready=0.
- flush, next state EMPTY:
  - overrides accept and pop in the same cycle.
  - any input offered in the flush cycle is discarded.
  - in_ready=1 the following cycle.
  - data registers need not clear; dout value is don't-care while out_valid=0.
- sel_err:
  - set the cycle after an accept with sel >= NUM_IN.
  - err_clr clears it.
  - simultaneous set and clear -> set wins.
  - flush does not clear it.
- With NUM_IN a power of two, sel_err can never set.
- Reset asserted mid-transfer: all in-flight words are lost; no partial state survives.

Decomposition:
- Shared package (processor-wide pkg): clog2 function, default WIDTH=16 word constant, BAD_VAL default constant.
- One natural sub-module: skid_buf, a generic WIDTH-bit 2-entry valid/ready register slice with flush.
- mux_nx1_pipe = combinational select + range check + skid_buf + sel_err flag.

Test Plan:
1. Reset, then stream with WIDTH=16, NUM_IN=4, din={0x4444,0x3333,0x2222,0x1111}, sel=0,1,2,3, out_ready=1 -> dout 0x1111,0x2222,0x3333,0x4444 on consecutive cycles, first one cycle after first accept; in_ready stays 1.
2. Backpressure: out_ready=0 while offering 3 words -> first two accepted, in_ready=0 after the second. Raise out_ready -> words emerge in order with no loss; in_ready returns to 1 the cycle after the first pop.
3. Flush in FULL with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, no word emitted; the offered word is never seen on dout.
4. NUM_IN=3, sel=3, din[0]=0xABCD -> dout=0x0000 (BAD_VAL), sel_err=1 next cycle. err_clr asserted together with another bad select -> sel_err stays 1; err_clr alone -> sel_err=0.
5. Async reset asserted mid-stream between clock edges -> out_valid=0, sel_err=0, in_ready=1 immediately, before the next edge.
6. Random valid/ready/sel/flush soak, 10k cycles, NUM_IN=5, WIDTH=32 -> scoreboard matches the in-order accepted words (minus flushed ones) exactly; dout stable whenever out_valid=1 and out_ready=0.
